// File: rtl/issue_queue_fifo_if.sv
// Enqueue/dequeue handshake bundle for issue_queue_fifo.
// master: the fetch producer and decode consumer side. slave: the queue itself.
interface issue_queue_fifo_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ENQ_WIDTH  = 2,
  parameter int DEQ_WIDTH  = 2
);
  logic [ENQ_WIDTH-1:0]            enq_valid;
  logic [ENQ_WIDTH*DATA_WIDTH-1:0] enq_data;
  logic                            enq_ready;
  logic [DEQ_WIDTH-1:0]            deq_valid;
  logic [DEQ_WIDTH*DATA_WIDTH-1:0] deq_data;
  logic [DEQ_WIDTH-1:0]            deq_ready;

  modport master (
    output enq_valid, enq_data, deq_ready,
    input  enq_ready, deq_valid, deq_data
  );

  modport slave (
    input  enq_valid, enq_data, deq_ready,
    output enq_ready, deq_valid, deq_data
  );
endinterface

// File: rtl/issue_queue_fifo.sv
// Multi-lane circular issue queue between fetch/predecode and decode.
// Up to ENQ_WIDTH compacted writes and DEQ_WIDTH in-order pops per cycle.
// Occupancy is held in its own counter so full and empty never alias.
// Every status output is a function of registered head/count only.
module issue_queue_fifo #(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 16,
  parameter int ENQ_WIDTH  = 2,
  parameter int DEQ_WIDTH  = 2,
  parameter int AF_MARGIN  = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           flush,
  issue_queue_fifo_if.slave              bus,
  output logic [$clog2(DEPTH+1)-1:0]     count,
  output logic                           empty,
  output logic                           full,
  output logic                           almost_full,
  output logic                           get_data_req,
  output logic                           overflow_err
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [PTR_W-1:0] head_reg, head_next;
  logic [PTR_W-1:0] tail_reg, tail_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             overflow_reg, overflow_next;

  logic [CNT_W-1:0] free_slots;
  logic [CNT_W-1:0] n_enq;
  logic [CNT_W-1:0] n_deq;
  logic [PTR_W-1:0] enq_off [ENQ_WIDTH];
  logic             deq_stop;
  logic             enq_any;
  logic             do_enq;

  // Status flags decoded from the registered occupancy.
  assign free_slots    = CNT_W'(DEPTH) - count_reg;
  assign bus.enq_ready = (free_slots >= CNT_W'(ENQ_WIDTH));
  assign almost_full   = (free_slots < CNT_W'(AF_MARGIN));
  assign get_data_req  = ~almost_full;
  assign empty         = (count_reg == '0);
  assign full          = (count_reg == CNT_W'(DEPTH));
  assign count         = count_reg;
  assign overflow_err  = overflow_reg;

  assign enq_any = |bus.enq_valid;
  assign do_enq  = enq_any && bus.enq_ready && !flush;

  // Read lanes: lane gi shows the entry at head+gi, zeroed when not occupied.
  genvar gi;
  generate
    for (gi = 0; gi < DEQ_WIDTH; gi++) begin : g_deq_lane
      assign bus.deq_valid[gi] = (count_reg > CNT_W'(gi));
      assign bus.deq_data[gi*DATA_WIDTH +: DATA_WIDTH] =
        bus.deq_valid[gi] ? mem[head_reg + PTR_W'(gi)] : '0;
    end
  endgenerate

  // Compact valid enqueue lanes: each lane's slot offset is the number of valid lanes below it.
  always_comb begin
    n_enq = '0;
    for (int i = 0; i < ENQ_WIDTH; i++) begin
      enq_off[i] = n_enq[PTR_W-1:0];
      if (bus.enq_valid[i]) n_enq = n_enq + CNT_ONE;
    end
  end

  // Pop count is the run of accepted lanes starting at lane 0; the first gap ends it.
  always_comb begin
    n_deq    = '0;
    deq_stop = 1'b0;
    for (int i = 0; i < DEQ_WIDTH; i++) begin
      if (!deq_stop && bus.deq_valid[i] && bus.deq_ready[i]) n_deq = n_deq + CNT_ONE;
      else deq_stop = 1'b1;
    end
  end

  // Next pointer/occupancy state; flush overrides both enqueue and dequeue.
  always_comb begin
    head_next     = head_reg;
    tail_next     = tail_reg;
    count_next    = count_reg;
    overflow_next = overflow_reg;
    if (flush) begin
      head_next  = '0;
      tail_next  = '0;
      count_next = '0;
    end else begin
      head_next  = head_reg + n_deq[PTR_W-1:0];
      tail_next  = do_enq ? tail_reg + n_enq[PTR_W-1:0] : tail_reg;
      count_next = count_reg + (do_enq ? n_enq : '0) - n_deq;
      if (enq_any && !bus.enq_ready) overflow_next = 1'b1;
    end
  end

  // Pointer, occupancy and sticky error registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_reg     <= '0;
      tail_reg     <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      head_reg     <= head_next;
      tail_reg     <= tail_next;
      count_reg    <= count_next;
      overflow_reg <= overflow_next;
    end
  end

  // Storage writes; contents are deliberately not cleared by reset or flush.
  always_ff @(posedge clk) begin
    if (do_enq) begin
      for (int i = 0; i < ENQ_WIDTH; i++) begin
        if (bus.enq_valid[i]) mem[tail_reg + enq_off[i]] <= bus.enq_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end
endmodule

// File: tb/tb_issue_queue_fifo.sv
// Directed bench for issue_queue_fifo with DEPTH=8, 2 lanes each way, AF_MARGIN=3.
module tb_issue_queue_fifo;
  localparam int DW = 64;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       flush;
  logic [3:0] count;
  logic       empty, full, almost_full, get_data_req, overflow_err;

  int checks   = 0;
  int failures = 0;

  issue_queue_fifo_if #(.DATA_WIDTH(DW), .ENQ_WIDTH(2), .DEQ_WIDTH(2)) bus ();

  issue_queue_fifo #(
    .DATA_WIDTH(DW), .DEPTH(8), .ENQ_WIDTH(2), .DEQ_WIDTH(2), .AF_MARGIN(3)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .bus          (bus),
    .count        (count),
    .empty        (empty),
    .full         (full),
    .almost_full  (almost_full),
    .get_data_req (get_data_req),
    .overflow_err (overflow_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] ev, input logic [63:0] d0, input logic [63:0] d1,
                       input logic [1:0] dr, input logic fl);
    bus.enq_valid = ev;
    bus.enq_data  = {d1, d0};
    bus.deq_ready = dr;
    flush         = fl;
  endtask

  task automatic idle();
    drive(2'b00, 64'd0, 64'd0, 2'b00, 1'b0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_enq_ready"},   bus.enq_ready, 1'b1);
    chk({tag, "_deq_valid"},   bus.deq_valid, 2'b00);
    chk({tag, "_deq_data"},    bus.deq_data, 128'd0);
    chk({tag, "_count"},       count, 4'd0);
    chk({tag, "_flags"},       {empty, full, almost_full, get_data_req}, 4'b1001);
    chk({tag, "_overflow"},    overflow_err, 1'b0);
  endtask

  localparam logic [63:0] A = 64'hAAAA_0000_0000_000A, B = 64'hBBBB_0000_0000_000B;
  localparam logic [63:0] C = 64'hCCCC_0000_0000_000C, D = 64'hDDDD_0000_0000_000D;
  localparam logic [63:0] E = 64'hEEEE_0000_0000_000E, F = 64'hFFFF_0000_0000_000F;
  localparam logic [63:0] R = 64'h1234_5678_9ABC_DEF0, S = 64'h5555_0000_0000_0005;
  localparam logic [63:0] T = 64'h7777_0000_0000_0007, U = 64'h0BAD_CAFE_0000_0001;

  initial begin
    rst_n = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals("rst");
    rst_n = 1'b1;

    // Dual write, idle, then single-lane pop.
    drive(2'b11, A, B, 2'b00, 1'b0);
    tick();
    idle();
    tick();
    chk("s1_deq_valid", bus.deq_valid, 2'b11);
    chk("s1_deq_data",  bus.deq_data, {B, A});
    chk("s1_count",     count, 4'd2);
    drive(2'b00, 64'd0, 64'd0, 2'b01, 1'b0);
    tick();
    idle();
    chk("s1_pop_valid", bus.deq_valid, 2'b01);
    chk("s1_pop_data",  bus.deq_data, {64'd0, B});
    chk("s1_pop_count", count, 4'd1);
    drive(2'b00, 64'd0, 64'd0, 2'b00, 1'b1);
    tick();
    idle();
    chk("s1_flush_count", count, 4'd0);

    // Fill toward full and probe the almost_full / enq_ready boundaries.
    for (int i = 0; i < 3; i++) begin
      drive(2'b11, 64'h100 + 64'(2*i), 64'h101 + 64'(2*i), 2'b00, 1'b0);
      tick();
      if (i == 1) chk("s2_af_at4", {count, almost_full, bus.enq_ready}, {4'd4, 1'b0, 1'b1});
    end
    chk("s2_at6", {count, bus.enq_ready, almost_full, get_data_req}, {4'd6, 1'b1, 1'b1, 1'b0});
    drive(2'b01, 64'h106, 64'd0, 2'b00, 1'b0);
    tick();
    chk("s2_at7", {count, bus.enq_ready, almost_full, get_data_req, full}, {4'd7, 1'b0, 1'b1, 1'b0, 1'b0});
    drive(2'b11, 64'hDEAD, 64'hBEEF, 2'b00, 1'b0);
    tick();
    idle();
    chk("s2_ovf_count", count, 4'd7);
    chk("s2_ovf_flag",  overflow_err, 1'b1);
    chk("s2_ovf_data",  bus.deq_data, {64'h101, 64'h100});
    drive(2'b00, 64'd0, 64'd0, 2'b00, 1'b1);
    tick();
    idle();
    chk("s2_flush", {count, empty, overflow_err}, {4'd0, 1'b1, 1'b1});

    // Walk head and tail to 7, then wrap a dual write across slots 7 and 0.
    for (int i = 0; i < 3; i++) begin
      drive(2'b11, 64'h200 + 64'(i), 64'h210 + 64'(i), 2'b00, 1'b0);
      tick();
    end
    drive(2'b01, 64'h2FF, 64'd0, 2'b00, 1'b0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(2'b00, 64'd0, 64'd0, 2'b11, 1'b0);
      tick();
    end
    drive(2'b00, 64'd0, 64'd0, 2'b01, 1'b0);
    tick();
    idle();
    chk("s3_drained", {count, empty}, {4'd0, 1'b1});
    drive(2'b11, C, D, 2'b00, 1'b0);
    tick();
    idle();
    chk("s3_wrap_data",  bus.deq_data, {D, C});
    chk("s3_wrap_count", count, 4'd2);
    drive(2'b00, 64'd0, 64'd0, 2'b11, 1'b0);
    tick();
    idle();
    chk("s3_pop", {count, empty, bus.deq_valid}, {4'd0, 1'b1, 2'b00});

    // Simultaneous dual enqueue and dual dequeue at count 4.
    drive(2'b11, 64'h300, 64'h301, 2'b00, 1'b0);
    tick();
    drive(2'b11, 64'h302, 64'h303, 2'b00, 1'b0);
    tick();
    chk("s4_count4", count, 4'd4);
    drive(2'b11, E, F, 2'b11, 1'b0);
    tick();
    idle();
    chk("s4_simul_count", count, 4'd4);
    chk("s4_simul_data",  bus.deq_data, {64'h303, 64'h302});
    drive(2'b00, 64'd0, 64'd0, 2'b11, 1'b0);
    tick();
    idle();
    chk("s4_ef", {count, bus.deq_data}, {4'd2, F, E});
    drive(2'b00, 64'd0, 64'd0, 2'b11, 1'b0);
    tick();
    idle();

    // Flush wins over same-cycle enqueue and dequeue.
    drive(2'b11, 64'h400, 64'h401, 2'b00, 1'b0);
    tick();
    drive(2'b11, 64'h402, 64'h403, 2'b00, 1'b0);
    tick();
    drive(2'b01, 64'h404, 64'd0, 2'b00, 1'b0);
    tick();
    chk("s5_count5", count, 4'd5);
    drive(2'b11, 64'h4AA, 64'h4BB, 2'b11, 1'b1);
    tick();
    idle();
    chk("s5_flush", {count, empty, bus.deq_valid}, {4'd0, 1'b1, 2'b00});
    chk("s5_flush_data", bus.deq_data, 128'd0);
    chk("s5_ovf_kept", overflow_err, 1'b1);
    drive(2'b10, 64'h0BAD, R, 2'b00, 1'b0);
    tick();
    idle();
    chk("s5_gap_write", {count, bus.deq_valid, bus.deq_data}, {4'd1, 2'b01, 64'd0, R});

    // Non-prefix pop request, then asynchronous reset in mid-cycle.
    drive(2'b11, S, T, 2'b00, 1'b0);
    tick();
    chk("s6_count3", count, 4'd3);
    drive(2'b00, 64'd0, 64'd0, 2'b10, 1'b0);
    tick();
    idle();
    chk("s6_nopop", {count, bus.deq_data}, {4'd3, S, R});
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("s6_async");
    #1;
    rst_n = 1'b1;
    drive(2'b01, U, 64'd0, 2'b00, 1'b0);
    tick();
    idle();
    chk("s6_post_rst", {count, bus.deq_valid, bus.deq_data}, {4'd1, 2'b01, 64'd0, U});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/issue_queue_fifo.md
# issue_queue_fifo

Parametrised multi-lane circular FIFO between instruction fetch/predecode and the decode/dispatch stage. It accepts up to ENQ_WIDTH entries and releases up to DEQ_WIDTH entries per cycle, with exact occupancy tracking. It provides per-lane valid/ready handshakes, a flush path for branch redirects, a programmable almost-full request throttle, and a sticky overflow error flag. It generalises the fixed dual-issue decode queue to arbitrary width, depth and lane count.

## Interface
- DATA_WIDTH, 64: bits per entry
- DEPTH, 16: entries; power of two, ≥ 2·max(ENQ_WIDTH, DEQ_WIDTH)
- ENQ_WIDTH, 2: enqueue lanes, 1..4
- DEQ_WIDTH, 2: dequeue lanes, 1..4
- AF_MARGIN, 4: free-slot threshold for almost_full, ENQ_WIDTH..DEPTH-1
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- flush  in  1  synchronous queue clear
- enq_valid  in  ENQ_WIDTH  per-lane write request
- enq_data  in  ENQ_WIDTH×DATA_WIDTH  lane i payload at slice i
- enq_ready  out  1  ≥ ENQ_WIDTH slots free
- deq_valid  out  DEQ_WIDTH  lane i holds an entry (count > i)
- deq_data  out  DEQ_WIDTH×DATA_WIDTH  entry at head+i
- deq_ready  in  DEQ_WIDTH  consumer pop request per lane
- count  out  clog2(DEPTH+1)  current occupancy
- empty  out  1  count == 0
- full  out  1  count == DEPTH
- almost_full  out  1  DEPTH − count < AF_MARGIN
- get_data_req  out  1  !almost_full; fetch-side throttle
- overflow_err  out  1  sticky overflow flag

## Operation
- Storage: DEPTH×DATA_WIDTH register array. head, tail: clog2(DEPTH) bits, wrap modulo DEPTH. count is kept separately, so full and empty are unambiguous.
- Enqueue: n_enq = popcount(enq_valid), accepted only when enq_ready. Valid lanes are compacted in ascending lane order into tail, tail+1, …; tail advances by n_enq. Gaps between valid lanes are allowed (e.g. enq_valid=2'b10 writes lane 1 to tail).
- enq_ready = (DEPTH − count) ≥ ENQ_WIDTH. It depends on the current count only; same-cycle dequeues are not credited.
- Rejected write (enq_valid≠0 && !enq_ready && !flush): no storage or pointer change; overflow_err sets and stays set until reset.
- Dequeue: n_deq = number of consecutive ones in deq_ready & deq_valid, starting at lane 0. A non-prefix bit stops the count (e.g. 2'b10 pops 0). head advances by n_deq.
- Lanes with deq_valid=0 drive deq_data=0.
- Simultaneous enqueue and dequeue: count_next = count + n_enq − n_deq. Dequeue reads pre-write contents; no write-to-read bypass.
- flush has priority over enqueue and dequeue in the same cycle. head, tail and count clear next edge; array contents are untouched; overflow_err is unaffected.
- rst_n low, asynchronous: head, tail, count and overflow_err clear to 0. Array contents are not reset.

## Timing
- Reset values: enq_ready=1, deq_valid=0, deq_data=0, count=0, empty=1, full=0, almost_full=0, get_data_req=1, overflow_err=0.
- Enqueue-to-visible latency is 1 cycle: data written at edge N appears on deq_data/deq_valid after edge N.
- deq_valid, deq_data, empty, full, almost_full and get_data_req are combinational from registered head/count only. There is no input-to-output combinational path.
- Dequeue takes effect at the clock edge where deq_ready & deq_valid hold; the next entries present in the following cycle.
- Wrap-around: a 2-lane write at tail=DEPTH−1 stores at slots DEPTH−1 and 0; the read at head+i is taken mod DEPTH.
- Reset deasserted mid-stream: first accepted enqueue lands at slot 0.

## Test plan
- Use DEPTH=8, ENQ_WIDTH=DEQ_WIDTH=2, AF_MARGIN=3 for all scenarios.
- Reset, then enq_valid=11 with A,B; idle one cycle → deq_valid=11, deq_data={B,A}, count=2; deq_ready=01 → next cycle lane0=B, deq_valid=01, count=1.
- Fill with 3 dual writes then one single → count=7, enq_ready=0, almost_full=1, get_data_req=0. Write enq_valid=11 → count stays 7, overflow_err=1 and remains 1 after a flush.
- Pre-fill to head=tail=7 by writing and then popping 7 entries. Write C,D → slots 7 and 0. Pop both → deq_data={D,C}, count returns to 0, empty=1.
- count=4; in one cycle enq 11 (E,F) and deq_ready=11 → count=4, the two oldest entries leave, E,F land at tail.
- count=5 with enq_valid=11, deq_ready=11 and flush=1 → next cycle count=0, empty=1, deq_valid=00, deq_data=0. A subsequent write lands at slot 0.
- deq_ready=10 with count=3 → no pop, count stays 3. Assert rst_n low mid-cycle → outputs take reset values immediately, before the next clock.
